// File: rtl/ultrasonic_ranger.sv
// Two-sensor HC-SR04 style ranger: triggers X then Y, times each echo,
// converts to centimetres and publishes the pair with a presence flag.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES         = 1000,
    parameter int CYCLES_PER_CM       = 5800,
    parameter int ECHO_TIMEOUT_CYCLES = 3000000,
    parameter int GAP_CYCLES          = 6000000,
    parameter int MAX_CM              = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       echo_x,
    input  logic       echo_y,
    output logic       trig_x,
    output logic       trig_y,
    output logic [7:0] dist_x,
    output logic [7:0] dist_y,
    output logic       sample_valid,
    output logic       present,
    output logic [1:0] err
);

    localparam int CNT_MAX0 = (ECHO_TIMEOUT_CYCLES > GAP_CYCLES) ?
                              ECHO_TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > TRIG_CYCLES) ?
                              CNT_MAX0 : TRIG_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int SW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST     = SW'(CYCLES_PER_CM - 1);
    localparam logic [8:0]    MAX_LIM      = 9'(MAX_CM);
    localparam bit            ONE_CM       = (CYCLES_PER_CM == 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_t;

    state_t        state, state_n;
    logic          sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] sub, sub_n;
    logic [7:0]    cm, cm_n;
    logic          rec;
    logic [7:0]    rec_val;
    logic          rec_err;
    logic [1:0]    sync_x, sync_y;
    logic          echo_s;
    logic [7:0]    x_hold;
    logic          x_err;

    // Two-flop synchronizers for the asynchronous echo lines
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_x <= 2'b00;
            sync_y <= 2'b00;
        end else begin
            sync_x <= {sync_x[0], echo_x};
            sync_y <= {sync_y[0], echo_y};
        end
    end

    assign echo_s = sel ? sync_y[1] : sync_x[1];
    assign trig_x = (state == TRIG) && !sel;
    assign trig_y = (state == TRIG) && sel;

    // State, sensor select and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            cnt   <= '0;
            sub   <= '0;
            cm    <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            sub   <= sub_n;
            cm    <= cm_n;
        end
    end

    // Next-state logic; the rise cycle counts as the first high cycle
    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt + 1'b1;
        sub_n   = sub;
        cm_n    = cm;
        rec     = 1'b0;
        rec_val = 8'hFF;
        rec_err = 1'b1;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = TRIG;
                    sel_n   = 1'b0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_n = WAIT_RISE;
                    cnt_n   = '0;
                end
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    state_n = MEASURE;
                    cnt_n   = '0;
                    sub_n   = ONE_CM ? '0 : SW'(1);
                    cm_n    = ONE_CM ? 8'd1 : 8'd0;
                end else if (cnt == TIMEOUT_LAST) begin
                    rec     = 1'b1;
                    state_n = GAP;
                    cnt_n   = '0;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    rec     = 1'b1;
                    rec_val = cm;
                    rec_err = 1'b0;
                    state_n = GAP;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    rec     = 1'b1;
                    state_n = GAP;
                    cnt_n   = '0;
                end else if (sub == SUB_LAST) begin
                    sub_n = '0;
                    cm_n  = (cm == 8'hFF) ? cm : cm + 8'd1;
                end else begin
                    sub_n = sub + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    sel_n   = ~sel;
                    state_n = sel ? IDLE : TRIG;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Hold the X result; publish the full pair when Y completes
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_x       <= 8'hFF;
            dist_y       <= 8'hFF;
            err          <= 2'b00;
            present      <= 1'b0;
            sample_valid <= 1'b0;
            x_hold       <= 8'hFF;
            x_err        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (rec && !sel) begin
                x_hold <= rec_val;
                x_err  <= rec_err;
            end else if (rec) begin
                dist_x       <= x_hold;
                dist_y       <= rec_val;
                err          <= {rec_err, x_err};
                present      <= ({1'b0, x_hold} < MAX_LIM)
                             && ({1'b0, rec_val} < MAX_LIM)
                             && !x_err && !rec_err;
                sample_valid <= 1'b1;
            end
        end
    end

endmodule
